// File: rtl/time_of_day_counter.sv
// time_of_day_counter: BCD hours/minutes/seconds with button-driven time setting.
// Latency: an input rising edge is sampled at edge 1, the pulse is visible after edge 2 and the counters update at edge 3.
// Backpressure: none; every second and every button press is applied once, and presses outside set mode are discarded.
//
// Ports:
//   clk_256Hz, reset_n       - board clock and asynchronous active-low reset
//   clk_1Hz                  - 1 Hz square wave; each rising edge is one second
//   set_mode                 - high halts timekeeping and enables inc_min / inc_hour
//   inc_min, inc_hour        - button levels; rising edges step minutes / hours in set mode
//   hours, minutes, seconds  - BCD time (tens in the upper bits, units in [3:0])
//   pm                       - PM flag (constant 0 in the 24-hour build)
//   sec_tick                 - one-cycle pulse per counted second
//
// Build option: define TWELVE_HOUR_EN for 12-hour operation (12, 01..11 with pm);
// the default build is 24-hour (00..23).

module time_of_day_counter (
  input  logic       clk_256Hz,
  input  logic       reset_n,
  input  logic       clk_1Hz,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [5:0] hours,
  output logic [6:0] minutes,
  output logic [6:0] seconds,
  output logic       pm,
  output logic       sec_tick
);

`ifdef TWELVE_HOUR_EN
  localparam logic [5:0] HOURS_RST = 6'h12;
`else
  localparam logic [5:0] HOURS_RST = 6'h00;
`endif

  // Bit 0: clk_1Hz, bit 1: inc_min, bit 2: inc_hour.
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] hist;
  logic [2:0] edge_next;

  logic tick_pulse;
  logic min_pulse;
  logic hour_pulse;

  assign raw = {inc_hour, inc_min, clk_1Hz};

  // The edge pulse is sync2 & ~hist. It is registered here, so the value
  // computed from sync1 & ~sync2 is what sync2 & ~hist becomes after this edge.
  // That is why the pulse is visible right after edge 2 and is applied at edge 3.
  assign edge_next = sync1 & ~sync2;

  always_ff @(posedge clk_256Hz or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
      hist  <= 3'b000;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // set_mode is sampled together with the pulse. A second arriving in set mode
  // and a press arriving outside set mode are both dropped here, not queued.
  always_ff @(posedge clk_256Hz or negedge reset_n) begin
    if (!reset_n) begin
      tick_pulse <= 1'b0;
      min_pulse  <= 1'b0;
      hour_pulse <= 1'b0;
    end else begin
      tick_pulse <= edge_next[0] & ~set_mode;
      min_pulse  <= edge_next[1] &  set_mode;
      hour_pulse <= edge_next[2] &  set_mode;
    end
  end

  assign sec_tick = tick_pulse;

  // This step is shared by seconds and minutes: 59 wraps to 00, and 09 goes to 10.
  function automatic logic [6:0] inc_mod60(input logic [6:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[6:4] == 3'd5) return 7'h00;
      else                return {v[6:4] + 3'd1, 4'd0};
    end
    return {v[6:4], v[3:0] + 4'd1};
  endfunction

`ifdef TWELVE_HOUR_EN
  // The 12-hour sequence is 12 -> 01 -> ... -> 09 -> 10 -> 11 -> 12.
  function automatic logic [5:0] inc_hours(input logic [5:0] v);
    if (v == 6'h12)        return 6'h01;
    if (v == 6'h11)        return 6'h12;
    if (v[3:0] == 4'd9)    return 6'h10;
    return {v[5:4], v[3:0] + 4'd1};
  endfunction
`else
  // The 24-hour sequence is 00..23, and 09 -> 10 and 19 -> 20 carry into the tens digit.
  function automatic logic [5:0] inc_hours(input logic [5:0] v);
    if (v == 6'h23)        return 6'h00;
    if (v[3:0] == 4'd9)    return {v[5:4] + 2'd1, 4'd0};
    return {v[5:4], v[3:0] + 4'd1};
  endfunction
`endif

  // pm flips only on the 11 -> 12 step, whether that step comes from counting or from a button.
  logic pm_flip_tick;
  logic pm_flip_set;

  assign pm_flip_tick = tick_pulse && seconds == 7'h59 && minutes == 7'h59 && hours == 6'h11;
  assign pm_flip_set  = hour_pulse && hours == 6'h11;

  // tick_pulse and the button pulses are mutually exclusive because they are
  // gated by opposite values of the same sampled set_mode. inc_min and
  // inc_hour may still fire together, and then both apply.
  always_ff @(posedge clk_256Hz or negedge reset_n) begin
    if (!reset_n) begin
      hours   <= HOURS_RST;
      minutes <= 7'h00;
      seconds <= 7'h00;
    end else begin
      if (tick_pulse) begin
        seconds <= inc_mod60(seconds);
        if (seconds == 7'h59) begin
          minutes <= inc_mod60(minutes);
          if (minutes == 7'h59) hours <= inc_hours(hours);
        end
      end
      if (min_pulse) begin
        minutes <= inc_mod60(minutes);
        seconds <= 7'h00;
      end
      if (hour_pulse) hours <= inc_hours(hours);
    end
  end

`ifdef TWELVE_HOUR_EN
  always_ff @(posedge clk_256Hz or negedge reset_n) begin
    if (!reset_n) pm <= 1'b0;
    else if (pm_flip_tick || pm_flip_set) pm <= ~pm;
  end
`else
  logic unused_pm;
  assign unused_pm = pm_flip_tick | pm_flip_set;
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: directed bench for time_of_day_counter with hand-computed BCD results.
// Latency: checks the 3-edge input-to-update path, the 256-cycle tick spacing and the asynchronous reset.
// Backpressure: not applicable; the bench drives all inputs directly.

module tb_time_of_day_counter;

  logic       clk_256Hz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       clk_1Hz   = 1'b0;
  logic       set_mode  = 1'b0;
  logic       inc_min   = 1'b0;
  logic       inc_hour  = 1'b0;
  logic [5:0] hours;
  logic [6:0] minutes;
  logic [6:0] seconds;
  logic       pm;
  logic       sec_tick;

  int checks = 0;
  int passed = 0;
  int tick_cnt = 0;
  int wide_cnt = 0;
  logic prev_tick = 1'b0;

  time_of_day_counter dut (
    .clk_256Hz (clk_256Hz),
    .reset_n   (reset_n),
    .clk_1Hz   (clk_1Hz),
    .set_mode  (set_mode),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds),
    .pm        (pm),
    .sec_tick  (sec_tick)
  );

  always #5 clk_256Hz = ~clk_256Hz;

  // This monitor counts sec_tick pulses and any that stay high for more than one cycle.
  always @(negedge clk_256Hz) begin
    if (sec_tick) begin
      tick_cnt++;
      if (prev_tick) wide_cnt++;
    end
    prev_tick = sec_tick;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk_256Hz);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_256Hz);
    reset_n = 1'b1;
  endtask

  // This is a short 1 Hz pulse; 4 cycles is enough for the 3-edge path to finish.
  task automatic fast_tick(input int n);
    for (int i = 0; i < n; i++) begin
      clk_1Hz = 1'b1;
      repeat (4) @(negedge clk_256Hz);
      clk_1Hz = 1'b0;
      repeat (4) @(negedge clk_256Hz);
    end
  endtask

  task automatic press(input logic m, input logic h, input int n);
    for (int i = 0; i < n; i++) begin
      inc_min  = m;
      inc_hour = h;
      repeat (4) @(negedge clk_256Hz);
      inc_min  = 1'b0;
      inc_hour = 1'b0;
      repeat (4) @(negedge clk_256Hz);
    end
  endtask

  initial begin
    int exp_s;

    // Reset state
    repeat (2) @(negedge clk_256Hz);
    check("rst_hours", hours, `ifdef TWELVE_HOUR_EN 'h12 `else 'h00 `endif);
    check("rst_minutes", minutes, 'h00);
    check("rst_seconds", seconds, 'h00);
    check("rst_pm", pm, 0);
    check("rst_tick", sec_tick, 0);
    reset_n = 1'b1;

    // 60 rising edges at the real 256-cycle period, with latency checked on the first edge
    tick_cnt = 0;
    wide_cnt = 0;
    for (int e = 0; e < 60; e++) begin
      clk_1Hz = 1'b1;
      for (int c = 1; c <= 128; c++) begin
        @(negedge clk_256Hz);
        if (e == 0 && c == 1) check("lat_e1_tick", sec_tick, 0);
        if (e == 0 && c == 2) begin
          check("lat_e2_tick", sec_tick, 1);
          check("lat_e2_sec", seconds, 'h00);
        end
        if (e == 0 && c == 3) begin
          check("lat_e3_sec", seconds, 'h01);
          check("lat_e3_tick", sec_tick, 0);
        end
      end
      clk_1Hz = 1'b0;
      repeat (128) @(negedge clk_256Hz);
      exp_s = (e + 1) % 60;
      check("run_sec", seconds, (exp_s / 10) * 16 + exp_s % 10);
    end
    check("run_min", minutes, 'h01);
    check("run_tick_cnt", tick_cnt, 60);
    check("run_tick_wide", wide_cnt, 0);

`ifdef TWELVE_HOUR_EN
    // 11:59:59 -> 12:00:00 sets pm; 12:59:59 -> 01:00:00 keeps it
    do_reset();
    set_mode = 1'b1;
    press(1'b0, 1'b1, 11);
    press(1'b1, 1'b0, 59);
    set_mode = 1'b0;
    fast_tick(59);
    check("h12_1159_h", hours, 'h11);
    check("h12_1159_m", minutes, 'h59);
    check("h12_1159_s", seconds, 'h59);
    check("h12_1159_pm", pm, 0);
    fast_tick(1);
    check("h12_noon_h", hours, 'h12);
    check("h12_noon_m", minutes, 'h00);
    check("h12_noon_s", seconds, 'h00);
    check("h12_noon_pm", pm, 1);
    set_mode = 1'b1;
    press(1'b1, 1'b0, 59);
    set_mode = 1'b0;
    fast_tick(59);
    check("h12_1259_h", hours, 'h12);
    check("h12_1259_s", seconds, 'h59);
    fast_tick(1);
    check("h12_one_h", hours, 'h01);
    check("h12_one_m", minutes, 'h00);
    check("h12_one_s", seconds, 'h00);
    check("h12_one_pm", pm, 1);
`else
    // 23:59:58 followed by two ticks rolls over to 00:00:00
    do_reset();
    set_mode = 1'b1;
    press(1'b0, 1'b1, 23);
    press(1'b1, 1'b0, 59);
    check("set_2359_h", hours, 'h23);
    check("set_2359_m", minutes, 'h59);
    set_mode = 1'b0;
    fast_tick(58);
    check("roll_s58", seconds, 'h58);
    fast_tick(1);
    check("roll_s59", seconds, 'h59);
    check("roll_h59", hours, 'h23);
    fast_tick(1);
    check("roll_h", hours, 'h00);
    check("roll_m", minutes, 'h00);
    check("roll_s", seconds, 'h00);
    // An inc_hour press outside set mode is discarded
    press(1'b0, 1'b1, 1);
    check("mask_hour", hours, 'h00);
    check("mask_min", minutes, 'h00);

    // Set mode freezes seconds, then inc_min at minute 59 wraps to 00 and clears seconds
    do_reset();
    set_mode = 1'b1;
    press(1'b0, 1'b1, 3);
    press(1'b1, 1'b0, 59);
    set_mode = 1'b0;
    fast_tick(5);
    check("frz_pre_s", seconds, 'h05);
    set_mode = 1'b1;
    tick_cnt = 0;
    fast_tick(3);
    check("frz_s", seconds, 'h05);
    check("frz_tick_cnt", tick_cnt, 0);
    press(1'b1, 1'b0, 1);
    check("frz_min_wrap_m", minutes, 'h00);
    check("frz_min_wrap_s", seconds, 'h00);
    check("frz_min_wrap_h", hours, 'h03);

    // Both buttons in the same cycle at 05:10:30 give 06:11:00
    do_reset();
    set_mode = 1'b1;
    press(1'b0, 1'b1, 5);
    press(1'b1, 1'b0, 10);
    set_mode = 1'b0;
    fast_tick(30);
    check("co_pre_s", seconds, 'h30);
    set_mode = 1'b1;
    press(1'b1, 1'b1, 1);
    check("co_h", hours, 'h06);
    check("co_m", minutes, 'h11);
    check("co_s", seconds, 'h00);
    press(1'b0, 1'b1, 18);
    check("set_h_wrap", hours, 'h00);
    set_mode = 1'b0;

    // Reset asserted mid-count at 14:27:33, then released with clk_1Hz high
    do_reset();
    set_mode = 1'b1;
    press(1'b0, 1'b1, 14);
    press(1'b1, 1'b0, 27);
    set_mode = 1'b0;
    fast_tick(33);
    check("mid_pre_h", hours, 'h14);
    check("mid_pre_m", minutes, 'h27);
    check("mid_pre_s", seconds, 'h33);
    #2 reset_n = 1'b0;
    #1;
    check("async_h", hours, 'h00);
    check("async_m", minutes, 'h00);
    check("async_s", seconds, 'h00);
    check("async_tick", sec_tick, 0);
    clk_1Hz = 1'b1;
    @(negedge clk_256Hz);
    reset_n = 1'b1;
    @(negedge clk_256Hz);
    check("rel_e1_s", seconds, 'h00);
    @(negedge clk_256Hz);
    check("rel_e2_tick", sec_tick, 1);
    check("rel_e2_s", seconds, 'h00);
    @(negedge clk_256Hz);
    check("rel_e3_s", seconds, 'h01);
    check("rel_e3_tick", sec_tick, 0);
    repeat (10) @(negedge clk_256Hz);
    check("rel_once_s", seconds, 'h01);
    clk_1Hz = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Time-of-day counter for the alarm clock. Consumes the 1 Hz clock from the timing generator, sampled in the 256 Hz board-clock domain. Keeps hours, minutes and seconds in BCD and supports button-driven time setting. Its outputs feed the display driver and the alarm comparator.

## Interface
- No parameters.
- `clk_256Hz`  in  1  board clock, 256 Hz; the only clock in this block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clk_1Hz`  in  1  1 Hz square wave from the timing generator; each rising edge is one second.
- `set_mode`  in  1  level. High means timekeeping is halted and the increment buttons are enabled.
- `inc_min`  in  1  button level; its rising edge increments minutes in set mode.
- `inc_hour`  in  1  button level; its rising edge increments hours in set mode.
- `hours`  out  6  BCD: bits [5:4] are tens, bits [3:0] are units.
- `minutes`  out  7  BCD: bits [6:4] are tens, bits [3:0] are units.
- `seconds`  out  7  BCD: bits [6:4] are tens, bits [3:0] are units.
- `pm`  out  1  PM flag. Tied to 0 when the 12-hour option is not compiled in.
- `sec_tick`  out  1  one-cycle pulse on each counted second.

## Operation
- **Input conditioning.** `clk_1Hz`, `inc_min` and `inc_hour` each pass through a 2-flop synchronizer followed by a history flop.
  - Edge pulse = sync2 & ~history.
  - All of these flops reset to 0.
- **Counting (set_mode = 0).** On a `clk_1Hz` edge pulse:
  - seconds increment; 59 wraps to 00 with a carry into minutes;
  - minutes 59 wraps to 00 with a carry into hours;
  - `sec_tick` = 1 for that cycle.
- **24-hour mode.** Hours run 00..23; 23:59:59 rolls to 00:00:00.
- **Set mode (set_mode = 1).**
  - `clk_1Hz` pulses are ignored and `sec_tick` stays 0.
  - An `inc_min` pulse increments minutes (59 wraps to 00, no hour carry) and clears seconds to 00.
  - An `inc_hour` pulse increments hours using the same wrap rules as counting, with no effect on minutes or seconds.
- **Simultaneous pulses.** If both `inc_min` and `inc_hour` pulse in the same cycle, both apply in that cycle.
- **Buttons outside set mode.** Button pulses while `set_mode` = 0 are discarded; they are not queued.
- **Mode changes.** `set_mode` takes effect on the next clock edge.
  - A tick pulse that coincides with `set_mode` = 1 is dropped.
  - Leaving set mode resumes counting from the held value.
- **BCD validity.** Every digit holds a valid BCD value at all times. The units digit carries into tens at 9 (for example, 09 → 10, 19 → 20).

## Timing
- **Reset values.** Asynchronous assertion sets:
  - 24-hour build: `hours` = 00, `minutes` = 00, `seconds` = 00, `pm` = 0, `sec_tick` = 0.
  - 12-hour build: `hours` = 12, `minutes` = 00, `seconds` = 00, `pm` = 0.
- **Latency.** Take the first `clk_256Hz` edge that samples `clk_1Hz` high as edge 1. `sec_tick` is high in the cycle following edge 2, and the counters update at edge 3. Button latency is identical.
- **Tick spacing.** `clk_1Hz` has a period of 256 clocks, so ticks are 256 cycles apart. Each rising edge yields exactly one increment, with no double count.
- **Reset mid-operation.** The counters and all input flops clear immediately.
  - If an input is already high when reset is released, it produces one edge pulse 2 edges after release.
  - A button held through reset in set mode therefore increments once.
- **Output registering.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `TWELVE_HOUR_EN`.
- **Defined:** hours run 12, 01..11.
  - 11:59:59 → 12:00:00 toggles `pm`.
  - 12:59:59 → 01:00:00 does not toggle `pm`.
  - In set mode, an `inc_hour` step from 11 to 12 toggles `pm`, and 12 → 01 does not.
- **Undefined:** 24-hour operation as described above; `pm` is constant 0.

## Test plan
- Release reset, drive `clk_1Hz` at 256-cycle period, run 60 rising edges → `seconds` goes 00..59 then 00, `minutes` = 01, with exactly 60 `sec_tick` pulses, each 1 cycle wide.
- 24-hour build, set time to 23:59:58, apply 2 ticks → 23:59:59, then 00:00:00.
- 12-hour build, set 11:59:59 with `pm` = 0, apply 1 tick → 12:00:00 with `pm` = 1. Then set 12:59:59 and apply 1 tick → 01:00:00 with `pm` unchanged.
- Set mode with a running clock: `set_mode` = 1 for 3 `clk_1Hz` edges → `seconds` frozen and no `sec_tick`. Pulse `inc_min` at minute 59 → minutes 00, seconds 00, hours unchanged.
- Button coincidence and masking:
  - In set mode, `inc_min` and `inc_hour` rising on the same clock at 05:10:30 → 06:11:00.
  - With `set_mode` = 0, an `inc_hour` pulse → no change.
- Assert `reset_n` low mid-count at 14:27:33 → outputs reach reset values without waiting for a clock edge. Release with `clk_1Hz` high → one increment to 00:00:01 on edge 3.
